udp_header_parser: RTL



---
 rtl/router_pkg.sv | 51 +++++
 rtl/udp_header_parser_if.sv | 39 +++
 rtl/sat_counter16.sv | 31 +++
 rtl/udp_header_parser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared layout constants, state encoding and header record for the ingress parser
package router_pkg;

    // Parser state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_HEADER  = 2'd0;
    localparam state_t ST_PAYLOAD = 2'd1;
    localparam state_t ST_DROP    = 2'd2;

    // Byte offsets of header fields within the Ethernet/IPv4/UDP frame
    localparam logic [5:0] OFF_DEST_MAC = 6'd0;
    localparam logic [5:0] OFF_SRC_MAC  = 6'd6;
    localparam logic [5:0] OFF_ETYPE    = 6'd12;
    localparam logic [5:0] OFF_VER_IHL  = 6'd14;
    localparam logic [5:0] OFF_PROTO    = 6'd23;
    localparam logic [5:0] OFF_IP_SRC   = 6'd26;
    localparam logic [5:0] OFF_IP_DST   = 6'd30;
    localparam logic [5:0] OFF_SPORT    = 6'd34;
    localparam logic [5:0] OFF_DPORT    = 6'd36;
    localparam logic [5:0] HDR_LEN      = 6'd42;
    localparam logic [5:0] HDR_LAST     = HDR_LEN - 6'd1;

    // Field widths in bytes
    localparam logic [5:0] LEN_MAC  = 6'd6;
    localparam logic [5:0] LEN_IP   = 6'd4;
    localparam logic [5:0] LEN_PORT = 6'd2;

    // Accepted protocol values
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IPPROTO_UDP    = 8'h11;

    // Extracted header as published downstream
    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] udp_sport;
        logic [15:0] udp_dport;
    } hdr_fields_t;

    // True when byte index cnt lies inside the field [off, off+len); wraps safely for cnt < off
    function automatic logic in_field(input logic [5:0] cnt, input logic [5:0] off,
                                      input logic [5:0] len);
        logic [5:0] rel;
        rel = cnt - off;
        return rel < len;
    endfunction

endpackage

// File: rtl/udp_header_parser_if.sv
// rtl/udp_header_parser_if.sv - stream, header and statistics bundle for the ingress parser
interface udp_header_parser_if;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;

    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [31:0] ip_dest_addr;
    logic [31:0] ip_src_addr;
    logic [15:0] udp_dest_port;
    logic [15:0] udp_src_port;
    logic        hdr_valid;

    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    // Parser side
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output dest_addr, src_addr, ip_dest_addr, ip_src_addr,
        output udp_dest_port, udp_src_port, hdr_valid, frames_ok, frames_dropped
    );

    // Frame source / payload sink / header consumer side
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  dest_addr, src_addr, ip_dest_addr, ip_src_addr,
        input  udp_dest_port, udp_src_port, hdr_valid, frames_ok, frames_dropped
    );
endinterface

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit event counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Increment on request unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/udp_header_parser.sv
// rtl/udp_header_parser.sv - byte-serial Ethernet/IPv4/UDP header extractor with payload pass-through
module udp_header_parser
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    udp_header_parser_if.slave bus
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;

    // Shadow registers fill while the header streams in; outputs never see partial values
    logic [47:0] dest_sh_q, dest_sh_d;
    logic [47:0] src_sh_q, src_sh_d;
    logic [7:0]  etype_hi_q, etype_hi_d;
    logic [31:0] ip_src_sh_q, ip_src_sh_d;
    logic [31:0] ip_dst_sh_q, ip_dst_sh_d;
    logic [15:0] sport_sh_q, sport_sh_d;
    logic [15:0] dport_sh_q, dport_sh_d;

    hdr_fields_t hdr_q, hdr_d;
    logic        hdr_valid_q, hdr_valid_d;

    logic        s_ready;
    logic        accept;
    logic        check_fail;
    logic        inc_ok;
    logic        inc_drop;
    logic [15:0] ok_count;
    logic [15:0] drop_count;

    // Input ready: only the payload state propagates downstream backpressure
    always_comb begin
        s_ready = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            s_ready = bus.m_axis_tready;
        end
    end

    assign accept = bus.s_axis_tvalid && s_ready;

    // Protocol checks on the byte being accepted in the header
    always_comb begin
        check_fail = 1'b0;
        if (cnt_q == OFF_ETYPE + 6'd1) begin
            check_fail = ({etype_hi_q, bus.s_axis_tdata} != ETHERTYPE_IPV4);
        end else if (cnt_q == OFF_VER_IHL) begin
            check_fail = (bus.s_axis_tdata != IPV4_VER_IHL);
        end else if (cnt_q == OFF_PROTO) begin
            check_fail = (bus.s_axis_tdata != IPPROTO_UDP);
        end
    end

    // Shadow capture: each field shifts in MSB first while its bytes pass in the header
    always_comb begin
        dest_sh_d   = dest_sh_q;
        src_sh_d    = src_sh_q;
        etype_hi_d  = etype_hi_q;
        ip_src_sh_d = ip_src_sh_q;
        ip_dst_sh_d = ip_dst_sh_q;
        sport_sh_d  = sport_sh_q;
        dport_sh_d  = dport_sh_q;
        if ((state_q == ST_HEADER) && accept) begin
            if (in_field(cnt_q, OFF_DEST_MAC, LEN_MAC)) begin
                dest_sh_d = {dest_sh_q[39:0], bus.s_axis_tdata};
            end
            if (in_field(cnt_q, OFF_SRC_MAC, LEN_MAC)) begin
                src_sh_d = {src_sh_q[39:0], bus.s_axis_tdata};
            end
            if (cnt_q == OFF_ETYPE) begin
                etype_hi_d = bus.s_axis_tdata;
            end
            if (in_field(cnt_q, OFF_IP_SRC, LEN_IP)) begin
                ip_src_sh_d = {ip_src_sh_q[23:0], bus.s_axis_tdata};
            end
            if (in_field(cnt_q, OFF_IP_DST, LEN_IP)) begin
                ip_dst_sh_d = {ip_dst_sh_q[23:0], bus.s_axis_tdata};
            end
            if (in_field(cnt_q, OFF_SPORT, LEN_PORT)) begin
                sport_sh_d = {sport_sh_q[7:0], bus.s_axis_tdata};
            end
            if (in_field(cnt_q, OFF_DPORT, LEN_PORT)) begin
                dport_sh_d = {dport_sh_q[7:0], bus.s_axis_tdata};
            end
        end
    end

    // Frame state machine, byte counter, header publication and statistic events
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        inc_ok      = 1'b0;
        inc_drop    = 1'b0;
        case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    if (check_fail) begin
                        // A failure on the tlast byte is a complete single drop
                        cnt_d = 6'd0;
                        if (bus.s_axis_tlast) begin
                            inc_drop = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else if (cnt_q == HDR_LAST) begin
                        cnt_d           = 6'd0;
                        hdr_d.dest_mac  = dest_sh_q;
                        hdr_d.src_mac   = src_sh_q;
                        hdr_d.ip_src    = ip_src_sh_q;
                        hdr_d.ip_dst    = ip_dst_sh_q;
                        hdr_d.udp_sport = sport_sh_q;
                        hdr_d.udp_dport = dport_sh_q;
                        hdr_valid_d     = 1'b1;
                        inc_ok          = 1'b1;
                        if (!bus.s_axis_tlast) begin
                            state_d = ST_PAYLOAD;
                        end
                    end else if (bus.s_axis_tlast) begin
                        // Runt frame: header never completed
                        cnt_d    = 6'd0;
                        inc_drop = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept && bus.s_axis_tlast) begin
                    state_d = ST_HEADER;
                end
            end
            ST_DROP: begin
                if (accept && bus.s_axis_tlast) begin
                    state_d  = ST_HEADER;
                    inc_drop = 1'b1;
                end
            end
            default: begin
                state_d = ST_HEADER;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State, counter, shadow and published-header registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_HEADER;
            cnt_q       <= 6'd0;
            dest_sh_q   <= 48'd0;
            src_sh_q    <= 48'd0;
            etype_hi_q  <= 8'd0;
            ip_src_sh_q <= 32'd0;
            ip_dst_sh_q <= 32'd0;
            sport_sh_q  <= 16'd0;
            dport_sh_q  <= 16'd0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dest_sh_q   <= dest_sh_d;
            src_sh_q    <= src_sh_d;
            etype_hi_q  <= etype_hi_d;
            ip_src_sh_q <= ip_src_sh_d;
            ip_dst_sh_q <= ip_dst_sh_d;
            sport_sh_q  <= sport_sh_d;
            dport_sh_q  <= dport_sh_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    sat_counter16 u_frames_ok (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_ok),
        .count  (ok_count)
    );

    sat_counter16 u_frames_dropped (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_drop),
        .count  (drop_count)
    );

    // Zero-latency payload path
    assign bus.s_axis_tready  = s_ready;
    assign bus.m_axis_tdata   = bus.s_axis_tdata;
    assign bus.m_axis_tvalid  = (state_q == ST_PAYLOAD) && bus.s_axis_tvalid;
    assign bus.m_axis_tlast   = (state_q == ST_PAYLOAD) && bus.s_axis_tlast;

    assign bus.dest_addr      = hdr_q.dest_mac;
    assign bus.src_addr       = hdr_q.src_mac;
    assign bus.ip_src_addr    = hdr_q.ip_src;
    assign bus.ip_dest_addr   = hdr_q.ip_dst;
    assign bus.udp_src_port   = hdr_q.udp_sport;
    assign bus.udp_dest_port  = hdr_q.udp_dport;
    assign bus.hdr_valid      = hdr_valid_q;
    assign bus.frames_ok      = ok_count;
    assign bus.frames_dropped = drop_count;

endmodule
